burst_ram_arbiter: RTL and testbench

//  Shares one BurstRAM between two cache requesters: port 0 = instruction cache, port 1 = data cache.

---
 rtl/burst_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single BurstRAM controller.
// A grant covers one whole burst; read beats are routed back, write beats pulled from the owner.
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s0_br_cmd,
    input  logic                                 s0_br_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        s0_br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   s0_br_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] s0_br_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   s0_br_rd_data,
    output logic                                 s0_br_rd_data_valid,
    output logic                                 s0_br_busy,
    output logic                                 s0_wr_beat,
    input  logic                                 s1_br_cmd,
    input  logic                                 s1_br_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        s1_br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   s1_br_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] s1_br_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   s1_br_rd_data,
    output logic                                 s1_br_rd_data_valid,
    output logic                                 s1_br_busy,
    output logic                                 s1_wr_beat,
    output logic                                 m_br_cmd,
    output logic                                 m_br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        m_br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   m_br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m_br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m_br_rd_data,
    input  logic                                 m_br_rd_data_valid,
    input  logic                                 m_br_busy
);

    localparam int AW = RAM_DEPTH_BITWIDTH;
    localparam int DW = RAM_BURST_DATA_BITWIDTH;
    localparam int MW = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int CW = $clog2(RAM_BURST_DATA_COUNT);
    localparam logic [CW-1:0] LAST_BEAT = CW'(RAM_BURST_DATA_COUNT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;
    localparam logic [1:0] ST_WR    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [AW-1:0] addr0_q, addr0_d;
    logic [AW-1:0] addr1_q, addr1_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] beat_q, beat_d;
    logic          m_cmd_en_q, m_cmd_en_d;
    logic          m_cmd_q, m_cmd_d;
    logic [AW-1:0] m_addr_q, m_addr_d;

    logic          in_flight_s;
    logic          rd_phase_s;
    logic          wr_phase_s;
    logic          last_beat_s;
    logic          done_s;
    logic [1:0]    active_s;
    logic [1:0]    cap_s;
    logic          win_s;

    assign in_flight_s = (state_q != ST_IDLE);
    assign rd_phase_s  = (state_q == ST_RD) || ((state_q == ST_ISSUE) && !m_cmd_q);
    assign wr_phase_s  = (state_q == ST_WR) || ((state_q == ST_ISSUE) && m_cmd_q);
    assign last_beat_s = (beat_q == LAST_BEAT);
    assign done_s      = (rd_phase_s && m_br_rd_data_valid && last_beat_s)
                       || ((state_q == ST_WR) && last_beat_s);

    // A port whose transaction ends this cycle may already queue its next request.
    assign active_s[0] = in_flight_s && (grant_q == 1'b0) && !done_s;
    assign active_s[1] = in_flight_s && (grant_q == 1'b1) && !done_s;
    assign cap_s[0]    = s0_br_cmd_en && !pend_q[0] && !active_s[0];
    assign cap_s[1]    = s1_br_cmd_en && !pend_q[1] && !active_s[1];

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        case (pend_q)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_grant_q;
            default: win_s = 1'b0;
        endcase
    end

    // Request capture and transaction sequencing.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        cmd_d        = cmd_q;
        addr0_d      = addr0_q;
        addr1_d      = addr1_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        m_cmd_en_d   = 1'b0;
        m_cmd_d      = m_cmd_q;
        m_addr_d     = m_addr_q;

        if (cap_s[0]) begin
            pend_d[0] = 1'b1;
            cmd_d[0]  = s0_br_cmd;
            addr0_d   = s0_br_addr;
        end else begin
            pend_d[0] = pend_q[0];
        end

        if (cap_s[1]) begin
            pend_d[1] = 1'b1;
            cmd_d[1]  = s1_br_cmd;
            addr1_d   = s1_br_addr;
        end else begin
            pend_d[1] = pend_q[1];
        end

        case (state_q)
            ST_IDLE: begin
                if ((pend_q != 2'b00) && !m_br_busy) begin
                    state_d        = ST_ISSUE;
                    m_cmd_en_d     = 1'b1;
                    m_cmd_d        = cmd_q[win_s];
                    m_addr_d       = win_s ? addr1_q : addr0_q;
                    pend_d[win_s]  = 1'b0;
                    grant_d        = win_s;
                    last_grant_d   = win_s;
                    beat_d         = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_cmd_q) begin
                    state_d = ST_WR;
                    beat_d  = beat_q + CW'(1);
                end else begin
                    state_d = ST_RD;
                    if (m_br_rd_data_valid) begin
                        beat_d = beat_q + CW'(1);
                    end else begin
                        beat_d = beat_q;
                    end
                end
            end
            ST_RD: begin
                if (m_br_rd_data_valid) begin
                    beat_d = beat_q + CW'(1);
                    if (last_beat_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_WR: begin
                beat_d = beat_q + CW'(1);
                if (last_beat_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State registers; reset abandons any burst already handed to the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= 2'b00;
            cmd_q        <= 2'b00;
            addr0_q      <= '0;
            addr1_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            m_cmd_en_q   <= 1'b0;
            m_cmd_q      <= 1'b0;
            m_addr_q     <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cmd_q        <= cmd_d;
            addr0_q      <= addr0_d;
            addr1_q      <= addr1_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            m_cmd_en_q   <= m_cmd_en_d;
            m_cmd_q      <= m_cmd_d;
            m_addr_q     <= m_addr_d;
        end
    end

    assign m_br_cmd_en = m_cmd_en_q;
    assign m_br_cmd    = m_cmd_q;
    assign m_br_addr   = m_addr_q;
    assign s0_br_busy  = pend_q[0] | (in_flight_s && (grant_q == 1'b0));
    assign s1_br_busy  = pend_q[1] | (in_flight_s && (grant_q == 1'b1));
    assign s0_wr_beat  = wr_phase_s && (grant_q == 1'b0);
    assign s1_wr_beat  = wr_phase_s && (grant_q == 1'b1);

    // Data steering between the RAM side and the granted requester.
    always_comb begin
        s0_br_rd_data       = '0;
        s1_br_rd_data       = '0;
        s0_br_rd_data_valid = 1'b0;
        s1_br_rd_data_valid = 1'b0;
        m_br_wr_data        = '0;
        m_br_data_mask      = '0;

        if (rd_phase_s) begin
            if (grant_q) begin
                s1_br_rd_data       = m_br_rd_data;
                s1_br_rd_data_valid = m_br_rd_data_valid;
            end else begin
                s0_br_rd_data       = m_br_rd_data;
                s0_br_rd_data_valid = m_br_rd_data_valid;
            end
        end else begin
            s0_br_rd_data_valid = 1'b0;
        end

        if (wr_phase_s) begin
            if (grant_q) begin
                m_br_wr_data   = s1_br_wr_data;
                m_br_data_mask = s1_br_data_mask;
            end else begin
                m_br_wr_data   = s0_br_wr_data;
                m_br_data_mask = s0_br_data_mask;
            end
        end else begin
            m_br_wr_data = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: hand-computed expectations for grants, beats and reset.
module tb_burst_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_br_cmd, s0_br_cmd_en, s1_br_cmd, s1_br_cmd_en;
    logic [7:0]  s0_br_addr, s1_br_addr;
    logic [63:0] s0_br_wr_data, s1_br_wr_data;
    logic [7:0]  s0_br_data_mask, s1_br_data_mask;
    logic [63:0] s0_br_rd_data, s1_br_rd_data;
    logic        s0_br_rd_data_valid, s1_br_rd_data_valid;
    logic        s0_br_busy, s1_br_busy, s0_wr_beat, s1_wr_beat;
    logic        m_br_cmd, m_br_cmd_en;
    logic [7:0]  m_br_addr;
    logic [63:0] m_br_wr_data;
    logic [7:0]  m_br_data_mask;
    logic [63:0] m_br_rd_data;
    logic        m_br_rd_data_valid, m_br_busy;

    int n_checks = 0;
    int n_errors = 0;

    burst_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_br_cmd(s0_br_cmd), .s0_br_cmd_en(s0_br_cmd_en), .s0_br_addr(s0_br_addr),
        .s0_br_wr_data(s0_br_wr_data), .s0_br_data_mask(s0_br_data_mask),
        .s0_br_rd_data(s0_br_rd_data), .s0_br_rd_data_valid(s0_br_rd_data_valid),
        .s0_br_busy(s0_br_busy), .s0_wr_beat(s0_wr_beat),
        .s1_br_cmd(s1_br_cmd), .s1_br_cmd_en(s1_br_cmd_en), .s1_br_addr(s1_br_addr),
        .s1_br_wr_data(s1_br_wr_data), .s1_br_data_mask(s1_br_data_mask),
        .s1_br_rd_data(s1_br_rd_data), .s1_br_rd_data_valid(s1_br_rd_data_valid),
        .s1_br_busy(s1_br_busy), .s1_wr_beat(s1_wr_beat),
        .m_br_cmd(m_br_cmd), .m_br_cmd_en(m_br_cmd_en), .m_br_addr(m_br_addr),
        .m_br_wr_data(m_br_wr_data), .m_br_data_mask(m_br_data_mask),
        .m_br_rd_data(m_br_rd_data), .m_br_rd_data_valid(m_br_rd_data_valid),
        .m_br_busy(m_br_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s0_br_cmd = 1'b0; s0_br_cmd_en = 1'b0; s0_br_addr = 8'h00;
        s1_br_cmd = 1'b0; s1_br_cmd_en = 1'b0; s1_br_addr = 8'h00;
        s0_br_wr_data = 64'h0; s1_br_wr_data = 64'h0;
        s0_br_data_mask = 8'h00; s1_br_data_mask = 8'h00;
        m_br_rd_data = 64'h0; m_br_rd_data_valid = 1'b0; m_br_busy = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Single request pulse; returns just after the capturing edge.
    task automatic pulse(input int port, input logic cmd, input logic [7:0] addr);
        if (port == 0) begin
            s0_br_cmd = cmd; s0_br_addr = addr; s0_br_cmd_en = 1'b1;
        end else begin
            s1_br_cmd = cmd; s1_br_addr = addr; s1_br_cmd_en = 1'b1;
        end
        cyc();
        s0_br_cmd_en = 1'b0;
        s1_br_cmd_en = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input int lat, input logic cmd,
                                input logic [7:0] addr);
        int n;
        n = 0;
        while (!m_br_cmd_en && n < 20) begin
            cyc();
            n++;
        end
        check_val({tag, "_latency"}, 64'(n), 64'(lat));
        check_val({tag, "_cmd"}, 64'(m_br_cmd), 64'(cmd));
        check_val({tag, "_addr"}, 64'(m_br_addr), 64'(addr));
    endtask

    // Called in the ISSUE cycle of a read; serves four beats and ends in the following IDLE cycle.
    task automatic rd_beats(input string tag, input int port, input logic [63:0] base);
        cyc();
        check_val({tag, "_cmd_en_one_cycle"}, 64'(m_br_cmd_en), 64'h0);
        for (int i = 0; i < 4; i++) begin
            m_br_rd_data = base + 64'(i);
            m_br_rd_data_valid = 1'b1;
            #1;
            if (port == 0) begin
                check_val({tag, "_rd_data"}, s0_br_rd_data, base + 64'(i));
                check_val({tag, "_other_valid"}, 64'(s1_br_rd_data_valid), 64'h0);
                check_val({tag, "_other_data"}, s1_br_rd_data, 64'h0);
            end else begin
                check_val({tag, "_rd_data"}, s1_br_rd_data, base + 64'(i));
                check_val({tag, "_other_valid"}, 64'(s0_br_rd_data_valid), 64'h0);
                check_val({tag, "_other_data"}, s0_br_rd_data, 64'h0);
            end
            cyc();
        end
        m_br_rd_data = 64'h0;
        m_br_rd_data_valid = 1'b0;
        #1;
        check_val({tag, "_busy_after"}, 64'(port == 0 ? s0_br_busy : s1_br_busy), 64'h0);
    endtask

    initial begin
        do_reset();
        #1;
        check_val("rst_s0_busy", 64'(s0_br_busy), 64'h0);
        check_val("rst_s1_busy", 64'(s1_br_busy), 64'h0);
        check_val("rst_cmd_en", 64'(m_br_cmd_en), 64'h0);
        check_val("rst_addr", 64'(m_br_addr), 64'h0);
        check_val("rst_wr_data", m_br_wr_data, 64'h0);

        // 1: single s0 read
        pulse(0, 1'b0, 8'h12);
        check_val("t1_busy_pend", 64'(s0_br_busy), 64'h1);
        expect_issue("t1", 1, 1'b0, 8'h12);
        rd_beats("t1", 0, 64'hA);

        // 2: tie after reset goes to s0, then s1; after a lone s0 grant a tie goes to s1
        do_reset();
        s0_br_cmd = 1'b0; s0_br_addr = 8'h20; s0_br_cmd_en = 1'b1;
        s1_br_cmd = 1'b0; s1_br_addr = 8'h21; s1_br_cmd_en = 1'b1;
        cyc();
        s0_br_cmd_en = 1'b0; s1_br_cmd_en = 1'b0;
        expect_issue("t2a_first", 1, 1'b0, 8'h20);
        rd_beats("t2a_first", 0, 64'h100);
        expect_issue("t2a_second", 1, 1'b0, 8'h21);
        rd_beats("t2a_second", 1, 64'h200);
        pulse(0, 1'b0, 8'h22);
        expect_issue("t2_lone", 1, 1'b0, 8'h22);
        rd_beats("t2_lone", 0, 64'h300);
        s0_br_cmd = 1'b0; s0_br_addr = 8'h23; s0_br_cmd_en = 1'b1;
        s1_br_cmd = 1'b0; s1_br_addr = 8'h24; s1_br_cmd_en = 1'b1;
        cyc();
        s0_br_cmd_en = 1'b0; s1_br_cmd_en = 1'b0;
        expect_issue("t2b_first", 1, 1'b0, 8'h24);
        rd_beats("t2b_first", 1, 64'h400);
        expect_issue("t2b_second", 1, 1'b0, 8'h23);
        rd_beats("t2b_second", 0, 64'h500);

        // 3: s1 write burst, beat 0 taken in the ISSUE cycle
        s1_br_data_mask = 8'hFF;
        pulse(1, 1'b1, 8'h40);
        expect_issue("t3", 1, 1'b1, 8'h40);
        for (int i = 1; i <= 4; i++) begin
            s1_br_wr_data = 64'(i);
            #1;
            check_val("t3_wr_beat", 64'(s1_wr_beat), 64'h1);
            check_val("t3_s0_wr_beat", 64'(s0_wr_beat), 64'h0);
            check_val("t3_wr_data", m_br_wr_data, 64'(i));
            check_val("t3_mask", 64'(m_br_data_mask), 64'hFF);
            cyc();
        end
        #1;
        check_val("t3_wr_beat_end", 64'(s1_wr_beat), 64'h0);
        check_val("t3_wr_data_end", m_br_wr_data, 64'h0);
        check_val("t3_mask_end", 64'(m_br_data_mask), 64'h0);
        check_val("t3_busy_end", 64'(s1_br_busy), 64'h0);
        s1_br_wr_data = 64'h0;
        s1_br_data_mask = 8'h00;

        // 4: s1 queued during an s0 burst; s0 re-requests in its completion cycle
        pulse(0, 1'b0, 8'h50);
        expect_issue("t4_s0", 1, 1'b0, 8'h50);
        cyc();
        for (int i = 0; i < 4; i++) begin
            m_br_rd_data = 64'h600 + 64'(i);
            m_br_rd_data_valid = 1'b1;
            if (i == 0) begin
                s1_br_cmd = 1'b0; s1_br_addr = 8'h55; s1_br_cmd_en = 1'b1;
            end
            if (i == 3) begin
                s0_br_cmd = 1'b0; s0_br_addr = 8'h66; s0_br_cmd_en = 1'b1;
            end
            #1;
            check_val("t4_s0_rd_data", s0_br_rd_data, 64'h600 + 64'(i));
            cyc();
            s0_br_cmd_en = 1'b0; s1_br_cmd_en = 1'b0;
            if (i == 0) begin
                check_val("t4_s1_busy_now", 64'(s1_br_busy), 64'h1);
            end
        end
        m_br_rd_data = 64'h0;
        m_br_rd_data_valid = 1'b0;
        #1;
        check_val("t4_idle_gap", 64'(m_br_cmd_en), 64'h0);
        check_val("t4_s0_recaptured", 64'(s0_br_busy), 64'h1);
        expect_issue("t4_s1", 1, 1'b0, 8'h55);
        rd_beats("t4_s1", 1, 64'h700);
        expect_issue("t4_s0_again", 1, 1'b0, 8'h66);
        rd_beats("t4_s0_again", 0, 64'h800);

        // 5: RAM busy holds off the grant
        m_br_busy = 1'b1;
        pulse(0, 1'b0, 8'h77);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("t5_blocked", 64'(m_br_cmd_en), 64'h0);
            check_val("t5_busy", 64'(s0_br_busy), 64'h1);
        end
        m_br_busy = 1'b0;
        cyc();
        check_val("t5_cmd_en", 64'(m_br_cmd_en), 64'h1);
        check_val("t5_addr", 64'(m_br_addr), 64'h77);
        rd_beats("t5", 0, 64'h900);

        // 6: asynchronous reset in the middle of a read burst
        pulse(0, 1'b0, 8'h88);
        expect_issue("t6", 1, 1'b0, 8'h88);
        cyc();
        m_br_rd_data = 64'hB0;
        m_br_rd_data_valid = 1'b1;
        cyc();
        m_br_rd_data = 64'hB1;
        #1;
        check_val("t6_pre_valid", 64'(s0_br_rd_data_valid), 64'h1);
        rst = 1'b0;
        #1;
        check_val("t6_rst_valid", 64'(s0_br_rd_data_valid), 64'h0);
        check_val("t6_rst_data", s0_br_rd_data, 64'h0);
        check_val("t6_rst_busy", 64'(s0_br_busy), 64'h0);
        check_val("t6_rst_cmd_en", 64'(m_br_cmd_en), 64'h0);
        m_br_rd_data = 64'h0;
        m_br_rd_data_valid = 1'b0;
        cyc();
        rst = 1'b1;
        pulse(0, 1'b0, 8'h99);
        expect_issue("t6_after", 1, 1'b0, 8'h99);
        rd_beats("t6_after", 0, 64'hC0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
